regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/wb_hold_buf.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  localparam int AGE_LIMIT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BOTH
  } arb_state_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer; Ready when empty or drained this cycle.
// Register-0 requests are accepted but never stored.
module wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     vld_i,
  output logic                     rdy_o,
  input  logic [REG_W-1:0]         reg_i,
  input  logic signed [DATA_W-1:0] dat_i,
  input  logic                     grant_i,
  output logic                     full_o,
  output logic                     full_nxt_o,
  output logic [REG_W-1:0]         reg_o,
  output logic signed [DATA_W-1:0] dat_o
);

  logic                     full_q, full_d;
  logic [REG_W-1:0]         reg_q, reg_d;
  logic signed [DATA_W-1:0] dat_q, dat_d;
  logic                     fill;

  assign rdy_o = ~rst_i & (~full_q | grant_i);
  assign fill  = vld_i & rdy_o & (reg_i != '0);

  always_comb begin
    full_d = full_q & ~grant_i;
    reg_d  = reg_q;
    dat_d  = dat_q;
    if (fill) begin
      full_d = 1'b1;
      reg_d  = reg_i;
      dat_d  = dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      reg_q  <= '0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      reg_q  <= reg_d;
      dat_q  <= dat_d;
    end
  end

  assign full_o     = full_q;
  assign full_nxt_o = full_d;
  assign reg_o      = reg_q;
  assign dat_o      = dat_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter, MEM over ALU, one registered write per cycle.
// WB_ARB_AGE_EN adds an ALU starvation counter forcing an ALU grant after AGE_LIMIT losses.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     AluValid,
  output logic                     AluReady,
  input  logic [REG_W-1:0]         AluReg,
  input  logic signed [DATA_W-1:0] AluData,
  input  logic                     MemValid,
  output logic                     MemReady,
  input  logic [REG_W-1:0]         MemReg,
  input  logic signed [DATA_W-1:0] MemData,
  output logic                     RegWrite,
  output logic [REG_W-1:0]         WriteReg,
  output logic signed [DATA_W-1:0] WriteData,
  output logic [(1<<REG_W)-1:0]    Pending
);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_age_range
    $error("AGE_LIMIT must be within 1..15");
  end

  logic                     alu_full, alu_nxt, alu_gnt;
  logic                     mem_full, mem_nxt, mem_gnt;
  logic [REG_W-1:0]         alu_reg, mem_reg;
  logic signed [DATA_W-1:0] alu_dat, mem_dat;
  logic                     force_alu;
  arb_state_e               state_q, state_d;
  logic                     rw_q, rw_d;
  logic [REG_W-1:0]         wr_q, wr_d;
  logic signed [DATA_W-1:0] wd_q, wd_d;
  logic [(1<<REG_W)-1:0]    pend;

  wb_hold_buf u_alu_buf (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .vld_i      (AluValid),
    .rdy_o      (AluReady),
    .reg_i      (AluReg),
    .dat_i      (AluData),
    .grant_i    (alu_gnt),
    .full_o     (alu_full),
    .full_nxt_o (alu_nxt),
    .reg_o      (alu_reg),
    .dat_o      (alu_dat)
  );

  wb_hold_buf u_mem_buf (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .vld_i      (MemValid),
    .rdy_o      (MemReady),
    .reg_i      (MemReg),
    .dat_i      (MemData),
    .grant_i    (mem_gnt),
    .full_o     (mem_full),
    .full_nxt_o (mem_nxt),
    .reg_o      (mem_reg),
    .dat_o      (mem_dat)
  );

  // In BOTH, MEM wins unless ALU has starved for AGE_LIMIT cycles.
  assign mem_gnt = mem_full & ~force_alu;
  assign alu_gnt = alu_full & ((state_q != BOTH) | force_alu);

`ifdef WB_ARB_AGE_EN
  localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);
  logic [3:0] age_q, age_d;

  assign force_alu = alu_full & (age_q == AGE_LIM);

  always_comb begin
    age_d = age_q;
    if (alu_gnt)       age_d = '0;
    else if (alu_full) age_d = age_q + 4'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  assign force_alu = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case ({alu_nxt, mem_nxt})
      2'b00:   state_d = IDLE;
      2'b11:   state_d = BOTH;
      default: state_d = SINGLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    rw_d = mem_gnt | alu_gnt;
    wr_d = wr_q;
    wd_d = wd_q;
    if (mem_gnt) begin
      wr_d = mem_reg;
      wd_d = mem_dat;
    end else if (alu_gnt) begin
      wr_d = alu_reg;
      wd_d = alu_dat;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rw_q <= 1'b0;
      wr_q <= '0;
      wd_q <= '0;
    end else begin
      rw_q <= rw_d;
      wr_q <= wr_d;
      wd_q <= wd_d;
    end
  end

  always_comb begin
    pend = '0;
    if (alu_full) pend[alu_reg] = 1'b1;
    if (mem_full) pend[mem_reg] = 1'b1;
    if (rw_q)     pend[wr_q]    = 1'b1;
    pend[0] = 1'b0;
  end

  assign RegWrite  = rw_q;
  assign WriteReg  = wr_q;
  assign WriteData = wd_q;
  assign Pending   = pend;

endmodule
